// File: rtl/fetch_redirect_ctrl_if.sv
// Redirect request/ack and fetch-control signals between the pipeline and fetch_redirect_ctrl.
// FETCH_CTRL_PERF_EN adds the stall_cycles performance counter output.
interface fetch_redirect_ctrl_if;
  logic        ex_redirect_req;
  logic [31:0] ex_redirect_addr;
  logic        br_redirect_req;
  logic [31:0] br_redirect_addr;
  logic        q_full;
  logic        halt_req;
  logic        ex_ack;
  logic        br_ack;
  logic        taken_branch1;
  logic [31:0] nextInstruction_address;
  logic        no_new_fetch;
  logic        FREEZE;
  logic        fetchNull2;
  logic        flush_IFID;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] stall_cycles;

  modport master (
    output ex_redirect_req, ex_redirect_addr, br_redirect_req, br_redirect_addr, q_full,
           halt_req,
    input  ex_ack, br_ack, taken_branch1, nextInstruction_address, no_new_fetch, FREEZE,
           fetchNull2, flush_IFID, stall_cycles
  );

  modport slave (
    input  ex_redirect_req, ex_redirect_addr, br_redirect_req, br_redirect_addr, q_full,
           halt_req,
    output ex_ack, br_ack, taken_branch1, nextInstruction_address, no_new_fetch, FREEZE,
           fetchNull2, flush_IFID, stall_cycles
  );
`else
  modport master (
    output ex_redirect_req, ex_redirect_addr, br_redirect_req, br_redirect_addr, q_full,
           halt_req,
    input  ex_ack, br_ack, taken_branch1, nextInstruction_address, no_new_fetch, FREEZE,
           fetchNull2, flush_IFID
  );

  modport slave (
    input  ex_redirect_req, ex_redirect_addr, br_redirect_req, br_redirect_addr, q_full,
           halt_req,
    output ex_ack, br_ack, taken_branch1, nextInstruction_address, no_new_fetch, FREEZE,
           fetchNull2, flush_IFID
  );
`endif
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: arbitrates exception/branch redirects, squashes fetch, handles halt.
// Define FETCH_CTRL_PERF_EN to add the saturating stall_cycles counter.
module fetch_redirect_ctrl #(
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  fetch_redirect_ctrl_if.slave  fr_io
);

  localparam logic [2:0] SquashLoad = 3'(SQUASH_CYCLES);

  typedef enum logic [1:0] {StRun, StHold, StSquash, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] nia_q, nia_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        taken_q, taken_d;
  logic        flush_q, flush_d;
  logic        ex_ack_q, ex_ack_d;
  logic        br_ack_q, br_ack_d;
  logic        freeze_q, freeze_d;
  logic        fnull_q, fnull_d;
  logic        blocked;

  assign blocked = fr_io.q_full | freeze_q;

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    nia_d       = nia_q;
    cnt_d       = cnt_q;
    taken_d     = 1'b0;
    flush_d     = 1'b0;
    ex_ack_d    = 1'b0;
    br_ack_d    = 1'b0;
    freeze_d    = freeze_q;
    fnull_d     = fnull_q;

    unique case (state_q)
      StRun: begin
        if (fr_io.ex_redirect_req) begin
          pend_addr_d = fr_io.ex_redirect_addr;
          ex_ack_d    = 1'b1;
          state_d     = StHold;
        end else if (fr_io.br_redirect_req) begin
          pend_addr_d = fr_io.br_redirect_addr;
          br_ack_d    = 1'b1;
          state_d     = StHold;
        end else if (fr_io.halt_req) begin
          freeze_d = 1'b1;
          state_d  = StHalt;
        end
      end
      StHold: begin
        // While ex_ack is visible the requester has not yet seen it; don't re-accept.
        if (fr_io.ex_redirect_req && !ex_ack_q) begin
          pend_addr_d = fr_io.ex_redirect_addr;
          ex_ack_d    = 1'b1;
        end else if (!blocked) begin
          taken_d = 1'b1;
          flush_d = 1'b1;
          nia_d   = pend_addr_q;
          cnt_d   = SquashLoad;
          fnull_d = 1'b1;
          state_d = StSquash;
        end
      end
      StSquash: begin
        if (fr_io.ex_redirect_req) begin
          pend_addr_d = fr_io.ex_redirect_addr;
          ex_ack_d    = 1'b1;
          fnull_d     = 1'b0;
          cnt_d       = 3'd0;
          state_d     = StHold;
        end else if (!blocked) begin
          if (cnt_q <= 3'd1) begin
            fnull_d = 1'b0;
            cnt_d   = 3'd0;
            state_d = StRun;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      StHalt: begin
        if (!fr_io.halt_req) begin
          freeze_d = 1'b0;
          state_d  = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= StRun;
      pend_addr_q <= 32'h0;
      nia_q       <= 32'h0;
      cnt_q       <= 3'd0;
      taken_q     <= 1'b0;
      flush_q     <= 1'b0;
      ex_ack_q    <= 1'b0;
      br_ack_q    <= 1'b0;
      freeze_q    <= 1'b0;
      fnull_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      nia_q       <= nia_d;
      cnt_q       <= cnt_d;
      taken_q     <= taken_d;
      flush_q     <= flush_d;
      ex_ack_q    <= ex_ack_d;
      br_ack_q    <= br_ack_d;
      freeze_q    <= freeze_d;
      fnull_q     <= fnull_d;
    end
  end

  assign fr_io.ex_ack                  = ex_ack_q;
  assign fr_io.br_ack                  = br_ack_q;
  assign fr_io.taken_branch1           = taken_q;
  assign fr_io.nextInstruction_address = nia_q;
  assign fr_io.no_new_fetch            = fr_io.q_full;
  assign fr_io.FREEZE                  = freeze_q;
  assign fr_io.fetchNull2              = fnull_q;
  assign fr_io.flush_IFID              = flush_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stall_q <= 32'h0;
    end else if ((fr_io.q_full | freeze_q | fnull_q) && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign fr_io.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed self-checking bench for fetch_redirect_ctrl (SQUASH_CYCLES = 2).
module tb_fetch_redirect_ctrl;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  fetch_redirect_ctrl_if fr_if ();

  fetch_redirect_ctrl #(
    .SQUASH_CYCLES(2)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .fr_io (fr_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_o(input string tag, input logic exa, input logic bra, input logic tb1,
                       input logic fl, input logic fn, input logic frz);
    chk({tag, ".ex_ack"},        32'(fr_if.ex_ack),        32'(exa));
    chk({tag, ".br_ack"},        32'(fr_if.br_ack),        32'(bra));
    chk({tag, ".taken_branch1"}, 32'(fr_if.taken_branch1), 32'(tb1));
    chk({tag, ".flush_IFID"},    32'(fr_if.flush_IFID),    32'(fl));
    chk({tag, ".fetchNull2"},    32'(fr_if.fetchNull2),    32'(fn));
    chk({tag, ".FREEZE"},        32'(fr_if.FREEZE),        32'(frz));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    RESET                   = 1'b0;
    fr_if.ex_redirect_req   = 1'b0;
    fr_if.ex_redirect_addr  = 32'h0;
    fr_if.br_redirect_req   = 1'b0;
    fr_if.br_redirect_addr  = 32'h0;
    fr_if.q_full            = 1'b0;
    fr_if.halt_req          = 1'b0;

    // Reset state
    step(); step();
    chk_o("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.nia", fr_if.nextInstruction_address, 32'h0);
`ifdef FETCH_CTRL_PERF_EN
    chk("reset.stall", fr_if.stall_cycles, 32'h0);
`endif
    RESET = 1'b1;
    step();

    // no_new_fetch follows q_full combinationally
    fr_if.q_full = 1'b1; #1;
    chk("nnf_hi", 32'(fr_if.no_new_fetch), 32'h1);
    fr_if.q_full = 1'b0; #1;
    chk("nnf_lo", 32'(fr_if.no_new_fetch), 32'h0);

    // Unblocked branch redirect
    fr_if.br_redirect_req = 1'b1; fr_if.br_redirect_addr = 32'h0000_0400;
    step(); fr_if.br_redirect_req = 1'b0;
    chk_o("br.c1", 0, 1, 0, 0, 0, 0);
    step();
    chk_o("br.c2", 0, 0, 1, 1, 1, 0);
    chk("br.c2.nia", fr_if.nextInstruction_address, 32'h400);
    step();
    chk_o("br.c3", 0, 0, 0, 0, 1, 0);
    step();
    chk_o("br.c4", 0, 0, 0, 0, 0, 0);
    chk("br.c4.nia_hold", fr_if.nextInstruction_address, 32'h400);

    // Simultaneous ex + br: ex wins, br held until back in RUN
    fr_if.ex_redirect_req = 1'b1; fr_if.ex_redirect_addr = 32'h80;
    fr_if.br_redirect_req = 1'b1; fr_if.br_redirect_addr = 32'h400;
    step(); fr_if.ex_redirect_req = 1'b0;
    chk_o("pri.c1", 1, 0, 0, 0, 0, 0);
    step();
    chk_o("pri.c2", 0, 0, 1, 1, 1, 0);
    chk("pri.c2.nia", fr_if.nextInstruction_address, 32'h80);
    step();
    chk_o("pri.c3", 0, 0, 0, 0, 1, 0);
    step();
    chk_o("pri.c4", 0, 0, 0, 0, 0, 0);
    step(); fr_if.br_redirect_req = 1'b0;
    chk_o("pri.c5", 0, 1, 0, 0, 0, 0);
    step();
    chk_o("pri.c6", 0, 0, 1, 1, 1, 0);
    chk("pri.c6.nia", fr_if.nextInstruction_address, 32'h400);
    step(); step();
    chk_o("pri.c8", 0, 0, 0, 0, 0, 0);

    // Blocked accept: HOLD while q_full high for 5 cycles
    fr_if.br_redirect_req = 1'b1; fr_if.br_redirect_addr = 32'h400; fr_if.q_full = 1'b1;
    step(); fr_if.br_redirect_req = 1'b0;
    chk_o("hold.c1", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("hold.wait%0d.tb1", i), 32'(fr_if.taken_branch1), 32'h0);
    end
    fr_if.q_full = 1'b0;
    step();
    chk_o("hold.issue", 0, 0, 1, 1, 1, 0);
    chk("hold.issue.nia", fr_if.nextInstruction_address, 32'h400);
    step();
    chk_o("hold.c7", 0, 0, 0, 0, 1, 0);
    step();
    chk_o("hold.c8", 0, 0, 0, 0, 0, 0);

    // Exception overrides a pending branch in HOLD
    fr_if.br_redirect_req = 1'b1; fr_if.br_redirect_addr = 32'h400; fr_if.q_full = 1'b1;
    step(); fr_if.br_redirect_req = 1'b0;
    chk("ovr.c1.br_ack", 32'(fr_if.br_ack), 32'h1);
    step();
    chk("ovr.c2.tb1", 32'(fr_if.taken_branch1), 32'h0);
    fr_if.ex_redirect_req = 1'b1; fr_if.ex_redirect_addr = 32'h80;
    step(); fr_if.ex_redirect_req = 1'b0; fr_if.q_full = 1'b0;
    chk_o("ovr.c3", 1, 0, 0, 0, 0, 0);
    step();
    chk_o("ovr.c4", 0, 0, 1, 1, 1, 0);
    chk("ovr.c4.nia", fr_if.nextInstruction_address, 32'h80);
    step();
    chk_o("ovr.c5", 0, 0, 0, 0, 1, 0);
    step();
    chk_o("ovr.c6", 0, 0, 0, 0, 0, 0);

    // Halt in RUN: 3 cycles of halt_req -> 3 cycles of FREEZE, one cycle later
    fr_if.halt_req = 1'b1;
    chk("halt.c0.frz", 32'(fr_if.FREEZE), 32'h0);
    step(); chk("halt.c1.frz", 32'(fr_if.FREEZE), 32'h1);
    step(); chk("halt.c2.frz", 32'(fr_if.FREEZE), 32'h1);
    step(); fr_if.halt_req = 1'b0;
    chk("halt.c3.frz", 32'(fr_if.FREEZE), 32'h1);
    step(); chk("halt.c4.frz", 32'(fr_if.FREEZE), 32'h0);

    // Halt during SQUASH is deferred until RUN
    fr_if.br_redirect_req = 1'b1; fr_if.br_redirect_addr = 32'h400;
    step(); fr_if.br_redirect_req = 1'b0;
    step();
    chk("hsq.c2.tb1", 32'(fr_if.taken_branch1), 32'h1);
    fr_if.halt_req = 1'b1;
    step();
    chk_o("hsq.c3", 0, 0, 0, 0, 1, 0);
    step();
    chk_o("hsq.c4", 0, 0, 0, 0, 0, 0);
    step(); fr_if.halt_req = 1'b0;
    chk("hsq.c5.frz", 32'(fr_if.FREEZE), 32'h1);
    step();
    chk("hsq.c6.frz", 32'(fr_if.FREEZE), 32'h0);

    // Reset asserted mid-SQUASH clears outputs immediately
    fr_if.br_redirect_req = 1'b1; fr_if.br_redirect_addr = 32'h400;
    step(); fr_if.br_redirect_req = 1'b0;
    step();
    chk("rsq.c2.fn", 32'(fr_if.fetchNull2), 32'h1);
    RESET = 1'b0; #1;
    chk_o("rsq.async", 0, 0, 0, 0, 0, 0);
    chk("rsq.async.nia", fr_if.nextInstruction_address, 32'h0);
`ifdef FETCH_CTRL_PERF_EN
    chk("rsq.async.stall", fr_if.stall_cycles, 32'h0);
`endif
    step(); step();
    RESET = 1'b1;
    fr_if.br_redirect_req = 1'b1; fr_if.br_redirect_addr = 32'h123;
    step(); fr_if.br_redirect_req = 1'b0;
    chk_o("rsq.run.c1", 0, 1, 0, 0, 0, 0);
    step();
    chk_o("rsq.run.c2", 0, 0, 1, 1, 1, 0);
    chk("rsq.run.c2.nia", fr_if.nextInstruction_address, 32'h123);
    step(); step();
    chk_o("rsq.run.c4", 0, 0, 0, 0, 0, 0);

    // Reset asserted mid-HOLD discards the pending redirect
    fr_if.br_redirect_req = 1'b1; fr_if.br_redirect_addr = 32'h400; fr_if.q_full = 1'b1;
    step(); fr_if.br_redirect_req = 1'b0;
    chk("rhd.c1.br_ack", 32'(fr_if.br_ack), 32'h1);
    step();
    RESET = 1'b0; #1;
    chk_o("rhd.async", 0, 0, 0, 0, 0, 0);
    step();
    RESET = 1'b1; fr_if.q_full = 1'b0;
    step();
    chk_o("rhd.post1", 0, 0, 0, 0, 0, 0);
    step();
    chk_o("rhd.post2", 0, 0, 0, 0, 0, 0);
    chk("rhd.post2.nia", fr_if.nextInstruction_address, 32'h0);

`ifdef FETCH_CTRL_PERF_EN
    // Counter accumulates only stalled cycles
    chk("perf.start", fr_if.stall_cycles, 32'h0);
    fr_if.q_full = 1'b1;
    step(); step(); step();
    fr_if.q_full = 1'b0;
    step();
    chk("perf.count", fr_if.stall_cycles, 32'h3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
